// File: rtl/timing_sequencer_pkg.sv
// timing_seq_pkg: shared state encoding and mode constants for the timing sequencer
package timing_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} seq_state_t;
  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;
endpackage

// File: rtl/timing_sequencer_decoder.sv
// phase_decoder: binary phase index to one-hot, forced to zero when not valid
module phase_decoder #(
  parameter int NUM_PHASES = 16,
  parameter int CNT_W = $clog2(NUM_PHASES)
) (
  input  logic [CNT_W-1:0]      idx,
  input  logic                  valid,
  output logic [NUM_PHASES-1:0] onehot
);
  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_bit
    assign onehot[i] = valid && (idx == CNT_W'(i));
  end
endmodule

// File: rtl/timing_sequencer.sv
// timing_sequencer: one-hot walking timing pulse generator with halt/step and single-shot modes
module timing_sequencer import timing_seq_pkg::*; #(
  parameter int NUM_PHASES = 16,
  parameter int CNT_W = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  start,
  input  logic [CNT_W-1:0]      last_phase,
  input  logic                  halt,
  input  logic                  step,
  input  logic                  clear,
  output logic [NUM_PHASES-1:0] T,
  output logic [CNT_W-1:0]      phase,
  output logic                  busy,
  output logic                  cycle_done
);
  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(NUM_PHASES - 1);
  seq_state_t state, state_nx;
  logic [CNT_W-1:0] last_q, last_nx, last_eff, phase_nx;
  logic [NUM_PHASES-1:0] t_nx;
  logic busy_nx, done_nx, adv;
  assign last_eff = (last_phase > MAX_P) ? MAX_P : last_phase;
  assign busy_nx = state_nx != IDLE;
  // the terminal index is only resampled at start and at wrap so a pass never changes length midway
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    last_nx = last_q;
    done_nx = 1'b0;
    adv = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      phase_nx = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nx = RUN;
          phase_nx = '0;
          last_nx = last_eff;
        end
        RUN: if (halt) state_nx = HALTED; else adv = enable;
        HALTED: if (!halt) state_nx = RUN; else adv = step;
        default: state_nx = IDLE;
      endcase
    end
    if (adv) begin
      if (phase != last_q) phase_nx = phase + 1'b1;
      else begin
        phase_nx = '0;
        done_nx = 1'b1;
        last_nx = last_eff;
        if (mode == MODE_SINGLE) state_nx = IDLE;
      end
    end
  end
  phase_decoder #(.NUM_PHASES(NUM_PHASES), .CNT_W(CNT_W)) u_dec (
    .idx(phase_nx),
    .valid(busy_nx),
    .onehot(t_nx)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      phase <= '0;
      T <= '0;
      busy <= 1'b0;
      cycle_done <= 1'b0;
      last_q <= MAX_P;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      T <= t_nx;
      busy <= busy_nx;
      cycle_done <= done_nx;
      last_q <= last_nx;
    end
  end
endmodule

// File: tb/tb_timing_sequencer.sv
// tb_timing_sequencer: vector table plus hand sequences for the timing sequencer
module tb_timing_sequencer;
  import timing_seq_pkg::*;
  logic clk = 0, reset = 0, enable = 0, mode = 0, start = 0, halt = 0, step = 0, clear = 0;
  logic [3:0] last_phase = 4'd15;
  logic [15:0] T;
  logic [3:0] phase;
  logic busy, cycle_done;
  logic start2 = 0;
  logic [3:0] last_phase2 = 4'd0;
  logic [9:0] T2;
  logic [3:0] phase2;
  logic busy2, cd2;
  always #5 clk = ~clk;
  timing_sequencer #(.NUM_PHASES(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start(start),
    .last_phase(last_phase), .halt(halt), .step(step), .clear(clear),
    .T(T), .phase(phase), .busy(busy), .cycle_done(cycle_done)
  );
  timing_sequencer #(.NUM_PHASES(10)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .mode(MODE_CONT), .start(start2),
    .last_phase(last_phase2), .halt(1'b0), .step(1'b0), .clear(1'b0),
    .T(T2), .phase(phase2), .busy(busy2), .cycle_done(cd2)
  );
  typedef struct packed {
    logic en, md, st, hl, sp, cl;
    logic [3:0] lp, ph;
    logic bz, cd;
  } vec_t;
  typedef struct packed {
    logic [15:0] t;
    logic [3:0] ph;
    logic bz, cd;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic void add(input logic en, md, st, hl, sp, cl, input logic [3:0] lp, ph,
                              input logic bz, cd);
    vecs.push_back('{en, md, st, hl, sp, cl, lp, ph, bz, cd});
  endfunction
  task automatic cyc(input vec_t v, input string nm);
    exp_t e, g;
    @(negedge clk);
    {enable, mode, start, halt, step, clear, last_phase} = {v.en, v.md, v.st, v.hl, v.sp, v.cl, v.lp};
    e.t = v.bz ? (16'd1 << v.ph) : 16'd0;
    e.ph = v.ph;
    e.bz = v.bz;
    e.cd = v.cd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({nm, " T"}, 32'(T), 32'(g.t));
    chk({nm, " phase"}, 32'(phase), 32'(g.ph));
    chk({nm, " busy"}, 32'(busy), 32'(g.bz));
    chk({nm, " cycle_done"}, 32'(cycle_done), 32'(g.cd));
  endtask
  task automatic run(input logic en, md, st, hl, sp, cl, input logic [3:0] lp, ph,
                     input logic bz, cd, input string nm);
    vec_t v;
    v = '{en, md, st, hl, sp, cl, lp, ph, bz, cd};
    cyc(v, nm);
  endtask
  initial begin
    // continuous full walk, with a stray start mid-run that must be ignored
    add(1, 0, 1, 0, 0, 0, 15, 0, 1, 0);
    for (int p = 1; p < 16; p++) add(1, 0, p == 5, 0, 0, 0, 15, 4'(p), 1, 0);
    add(1, 0, 0, 0, 0, 0, 15, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 15, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 15, 0, 0, 0);
    // single-shot to 5, then restart
    add(1, 1, 1, 0, 0, 0, 5, 0, 1, 0);
    for (int p = 1; p < 6; p++) add(1, 1, 0, 0, 0, 0, 5, 4'(p), 1, 0);
    add(1, 1, 0, 0, 0, 0, 5, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 5, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 5, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    add(0, 1, 0, 0, 0, 1, 5, 0, 0, 0);
    // enable gating with terminal 3
    add(1, 0, 1, 0, 0, 0, 3, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 3, 2, 1, 0);
    add(1, 0, 0, 0, 0, 0, 3, 3, 1, 0);
    add(1, 0, 0, 0, 0, 0, 3, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    // terminal 0: every enabled edge is a wrap
    add(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // halt at 7, step to 10, resume, halt beats terminal, terminal step wraps
    add(1, 0, 1, 0, 0, 0, 15, 0, 1, 0);
    for (int p = 1; p < 8; p++) add(1, 0, 0, 0, 0, 0, 15, 4'(p), 1, 0);
    for (int k = 0; k < 11; k++) add(1, 0, 0, 1, 0, 0, 15, 7, 1, 0);
    for (int p = 8; p < 11; p++) begin
      add(0, 0, 0, 1, 1, 0, 15, 4'(p), 1, 0);
      add(0, 0, 0, 1, 0, 0, 15, 4'(p), 1, 0);
    end
    add(1, 0, 0, 0, 0, 0, 15, 10, 1, 0);
    for (int p = 11; p < 16; p++) add(1, 0, 0, 0, 0, 0, 15, 4'(p), 1, 0);
    add(1, 0, 0, 1, 0, 0, 15, 15, 1, 0);
    add(1, 0, 0, 1, 1, 0, 15, 0, 1, 1);
    add(1, 0, 0, 1, 1, 1, 15, 0, 0, 0);
    // single-shot terminal step exits to IDLE
    add(1, 1, 1, 0, 0, 0, 2, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 2, 1, 1, 0);
    add(1, 1, 0, 1, 0, 0, 2, 1, 1, 0);
    add(0, 1, 0, 1, 1, 0, 2, 2, 1, 0);
    add(0, 1, 0, 1, 0, 0, 2, 2, 1, 0);
    add(0, 1, 0, 1, 1, 0, 2, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    #2;
    chk("reset T", 32'(T), 0);
    chk("reset phase", 32'(phase), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset cycle_done", 32'(cycle_done), 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < vecs.size(); i++) cyc(vecs[i], $sformatf("vec%0d", i));
    // asynchronous reset mid-cycle at phase 9
    run(1, 0, 1, 0, 0, 0, 15, 0, 1, 0, "ar start");
    for (int p = 1; p < 10; p++) run(1, 0, 0, 0, 0, 0, 15, 4'(p), 1, 0, "ar walk");
    #2 reset = 0;
    #1;
    chk("async T", 32'(T), 0);
    chk("async busy", 32'(busy), 0);
    chk("async phase", 32'(phase), 0);
    @(negedge clk);
    reset = 1;
    run(1, 0, 0, 0, 0, 0, 15, 0, 0, 0, "ar idle");
    run(1, 0, 1, 0, 0, 0, 15, 0, 1, 0, "ar restart");
    for (int p = 1; p < 5; p++) run(1, 0, 0, 0, 0, 0, 15, 4'(p), 1, 0, "cl walk");
    run(1, 0, 0, 0, 0, 1, 15, 0, 0, 0, "cl clear");
    run(1, 0, 0, 0, 0, 0, 15, 0, 0, 0, "cl idle");
    // clamp to 9 on a 10-phase instance, then shorten terminal mid-pass
    for (int k = 0; k < 15; k++) begin
      int ep;
      @(negedge clk);
      {start, halt, step, clear, enable} = 5'b00001;
      start2 = (k == 0);
      last_phase2 = (k < 5) ? 4'd12 : 4'd2;
      ep = (k < 10) ? k : (k - 10) % 3;
      @(posedge clk);
      #1;
      chk($sformatf("clamp%0d phase", k), 32'(phase2), 32'(ep));
      chk($sformatf("clamp%0d T", k), 32'(T2), 32'(10'd1 << ep));
      chk($sformatf("clamp%0d cycle_done", k), 32'(cd2), 32'(k == 10 || k == 13));
    end
    chk("clamp busy", 32'(busy2), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
